fp16_align_stage: RTL

- Pipelined operand-alignment front end of the half-precision floating-point adder.
- Unpacks two FP16 operands and orders them by magnitude: larger operand is "big", smaller is "small".
- Computes the exponent difference and registers big/small mantissas, exponent, signs and shift magnitude.
- The downstream right barrel shifter (11-bit data, 5-bit shift) shifts small_mant by shift_mag combinationally; outputs use a valid/ready handshake.

---
 rtl/fp16_align_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fp16_align_stage.sv
// fp16_align_stage: two-stage alignment front end of the half-precision adder.
// Stage 1 registers the raw operands. Stage 2 registers the magnitude-ordered
// mantissas, the exponent difference, the signs and the special flag. A
// valid/ready handshake runs between the stages, with no skid buffer.
module fp16_align_stage #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [MAN_W:0]     big_mant,
  output logic [MAN_W:0]     small_mant,
  output logic [EXP_W-1:0]   shift_mag,
  output logic [EXP_W-1:0]   big_exp,
  output logic               sign_big,
  output logic               sign_small,
  output logic               eff_sub,
  output logic               special,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int OP_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Stage 1 storage: the raw operands
  // ---------------------------------------------------------------------------
  logic              s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;

  // ---------------------------------------------------------------------------
  // Stage 2 storage: the alignment fields, which drive the outputs directly
  // ---------------------------------------------------------------------------
  logic              out_valid_q, out_valid_d;
  logic [MAN_W:0]    big_mant_q, big_mant_d;
  logic [MAN_W:0]    small_mant_q, small_mant_d;
  logic [EXP_W-1:0]  shift_mag_q, shift_mag_d;
  logic [EXP_W-1:0]  big_exp_q, big_exp_d;
  logic              sign_big_q, sign_big_d;
  logic              sign_small_q, sign_small_d;
  logic              special_q, special_d;

  // Handshake controls
  logic s2_free;
  logic s1_load;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign s1_load  = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Unpack both stage-1 operands. Index 0 is A and index 1 is B.
  // ---------------------------------------------------------------------------
  logic [OP_W-1:0]        op       [2];
  logic                   op_sign  [2];
  logic [EXP_W-1:0]       op_exp   [2];
  logic [MAN_W-1:0]       op_frac  [2];
  logic [EXP_W-1:0]       op_eexp  [2];
  logic [MAN_W:0]         op_mant  [2];
  logic                   op_inf   [2];
  logic [EXP_W+MAN_W-1:0] op_mag   [2];

  assign op[0] = a_q;
  assign op[1] = b_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_sign[gi] = op[gi][OP_W-1];
      assign op_exp[gi]  = op[gi][EXP_W+MAN_W-1:MAN_W];
      assign op_frac[gi] = op[gi][MAN_W-1:0];
      // A subnormal uses the same scale as exponent 1, with no hidden bit.
      assign op_eexp[gi] = (op_exp[gi] == '0) ? EXP_ONE : op_exp[gi];
      assign op_mant[gi] = {(op_exp[gi] != '0), op_frac[gi]};
      assign op_inf[gi]  = (op_exp[gi] == EXP_MAX);
      // The magnitude key ignores the sign bit.
      assign op_mag[gi]  = op[gi][EXP_W+MAN_W-1:0];
    end
  endgenerate

  // Ordering: A wins ties, so the exponent difference is never negative.
  logic                 a_is_big;
  logic [EXP_W-1:0]     cmp_big_eexp;
  logic [EXP_W-1:0]     cmp_small_eexp;

  assign a_is_big       = (op_mag[0] >= op_mag[1]);
  assign cmp_big_eexp   = a_is_big ? op_eexp[0] : op_eexp[1];
  assign cmp_small_eexp = a_is_big ? op_eexp[1] : op_eexp[0];

  // Stage 1 next state: capture operands only on an accepted transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (s1_load) begin
      a_d = a;
      b_d = b;
    end
  end

  // Stage 2 next state: load fields when stage 1 moves forward, else hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    big_mant_d   = big_mant_q;
    small_mant_d = small_mant_q;
    shift_mag_d  = shift_mag_q;
    big_exp_d    = big_exp_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    special_d    = special_q;
    if (s2_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        big_mant_d   = a_is_big ? op_mant[0] : op_mant[1];
        small_mant_d = a_is_big ? op_mant[1] : op_mant[0];
        sign_big_d   = a_is_big ? op_sign[0] : op_sign[1];
        sign_small_d = a_is_big ? op_sign[1] : op_sign[0];
        big_exp_d    = cmp_big_eexp;
        shift_mag_d  = cmp_big_eexp - cmp_small_eexp;
        special_d    = op_inf[0] || op_inf[1];
      end
    end
  end

  // Pipeline registers. Reset clears everything, including in-flight items.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      big_mant_q   <= '0;
      small_mant_q <= '0;
      shift_mag_q  <= '0;
      big_exp_q    <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      special_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      big_mant_q   <= big_mant_d;
      small_mant_q <= small_mant_d;
      shift_mag_q  <= shift_mag_d;
      big_exp_q    <= big_exp_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      special_q    <= special_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign big_mant   = big_mant_q;
  assign small_mant = small_mant_q;
  assign shift_mag  = shift_mag_q;
  assign big_exp    = big_exp_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign eff_sub    = sign_big_q ^ sign_small_q;
  assign special    = special_q;

endmodule
